// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-word async SRAM controller with configurable wait states.
// Optional byte-lane enables via `SRAM_BYTE_LANE_EN.
module sram_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req,
  input  logic        wr,
  input  logic [19:0] addr,
  input  logic [15:0] wdata,
`ifdef SRAM_BYTE_LANE_EN
  input  logic [1:0]  be,
`endif
  output logic [15:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE,
  output logic [19:0] ADDR,
  inout  wire  [15:0] Data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ACC,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_DONE
  } state_t;

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [19:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic [1:0]  w_be;
  logic        w_drive;

`ifdef SRAM_BYTE_LANE_EN
  logic [1:0]  r_be;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_be <= 2'b11;
    end else if (r_state == S_IDLE && req) begin
      r_be <= be;
    end
  end

  assign w_be = r_be;
`else
  assign w_be = 2'b11;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (req) w_next = wr ? S_WR_SETUP : S_RD_ACC;
      S_RD_ACC:   if (r_cnt == 4'd0) w_next = S_DONE;
      S_WR_SETUP: w_next = S_WR_PULSE;
      S_WR_PULSE: if (r_cnt == 4'd0) w_next = S_WR_HOLD;
      S_WR_HOLD:  w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 20'd0;
      r_wdata <= 16'd0;
      r_rdata <= 16'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && req) begin
        r_addr  <= addr;
        r_wdata <= wdata;
        r_cnt   <= LP_WAIT;
      end else if ((r_state == S_RD_ACC || r_state == S_WR_PULSE) && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == S_RD_ACC && r_cnt == 4'd0) begin
        r_rdata <= Data;
      end
    end
  end

  // Pins decode from registered state only, so req never reaches the SRAM combinationally.
  always_comb begin
    CE      = 1'b1;
    UB      = 1'b1;
    LB      = 1'b1;
    OE      = 1'b1;
    WE      = 1'b1;
    w_drive = 1'b0;
    case (r_state)
      S_RD_ACC: begin
        CE = 1'b0;
        OE = 1'b0;
        UB = 1'b0;
        LB = 1'b0;
      end
      S_WR_SETUP, S_WR_PULSE, S_WR_HOLD: begin
        CE      = 1'b0;
        UB      = ~w_be[1];
        LB      = ~w_be[0];
        w_drive = 1'b1;
        if (r_state == S_WR_PULSE) WE = ~(|w_be);
      end
      default: ;
    endcase
  end

  assign ADDR  = r_addr;
  assign rdata = r_rdata;
  assign ready = (r_state == S_DONE);
  assign busy  = (r_state != S_IDLE);
  assign Data  = w_drive ? r_wdata : 16'hzzzz;

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Memory-side stage directly downstream of the CPU datapath in the lab6 top level.
- Turns single-word read/write requests (address, write data, write flag) into timed, active-low SRAM pin sequences on CE/UB/LB/OE/WE/ADDR/Data.
- Returns read data with a one-cycle ready pulse.
- Makes SRAM access deterministic and wait-state configurable, so the bus-control FSM only issues req and waits for ready.

Parameters:
- WAIT_CYCLES, 1, extra access cycles beyond the minimum; legal range 0..15; internal counter is 4 bits.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- req  in  1  request strobe; sampled only in IDLE.
- wr  in  1  1 = write, 0 = read; sampled with req.
- addr  in  20  word address; latched on accept.
- wdata  in  16  write data; latched on accept.
- rdata  out  16  read data; holds the last read value until the next read completes.
- ready  out  1  one-cycle pulse marking transaction completion.
- busy  out  1  high in every state except IDLE.
- CE  out  1  SRAM chip enable, active-low.
- UB  out  1  SRAM upper byte enable, active-low.
- LB  out  1  SRAM lower byte enable, active-low.
- OE  out  1  SRAM output enable, active-low.
- WE  out  1  SRAM write enable, active-low.
- ADDR  out  20  SRAM address.
- Data  inout  16  SRAM data bus; driven only in write states, high-Z otherwise.

Behaviour:
- Reset values: CE=UB=LB=OE=WE=1; ADDR=0; Data=Z; rdata=0; ready=0; busy=0; state=IDLE; counter=0.
- All outputs are registered, i.e. decoded from state registers only; no combinational path from req to any pin.
- States: IDLE, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE:
  - req=1 at an edge → latch addr/wdata/wr, load counter=WAIT_CYCLES.
  - Go to RD_ACC (wr=0) or WR_SETUP (wr=1).
- RD_ACC: CE=0, OE=0, UB=LB=0, ADDR=latched address, WE=1, Data=Z.
  - Counter decrements each edge.
  - At the edge where counter==0: rdata<=Data, go to DONE.
  - Total duration WAIT_CYCLES+1 cycles.
- WR_SETUP (1 cycle): CE=0, UB=LB=0, OE=1, WE=1, ADDR valid, Data=latched wdata.
- WR_PULSE (WAIT_CYCLES+1 cycles): same as WR_SETUP but WE=0.
- WR_HOLD (1 cycle): WE=1; CE, ADDR and Data still held, giving address/data hold after the WE rising edge. Then go to DONE.
- DONE (1 cycle): all strobes deasserted, Data=Z, ready=1. Next edge → IDLE.
- Latency from the accept edge to the ready cycle:
  - read = WAIT_CYCLES+1 cycles;
  - write = WAIT_CYCLES+3 cycles.
- Earliest next accept is the edge that ends DONE+1, i.e. one IDLE cycle between transactions.
- req while busy=1 is ignored; there is no queue. The requester must hold req until it sees ready, or re-issue it.
- req held high continuously → a new transaction starts on each IDLE edge.
- OE and WE are never low in the same cycle.
- Data is never driven while OE=0.
- Reset asserted mid-transaction → at that edge all outputs return to reset values and Data is released. No ready pulse for the aborted transaction; rdata is cleared.
- addr/wdata changes after accept have no effect on the current transaction.

Optional Feature:
- Macro SRAM_BYTE_LANE_EN.
- Defined:
  - Adds input be[1:0], latched with req.
  - During write states UB=~be[1] and LB=~be[0]; reads always enable both lanes.
  - be=00 on a write → normal state timing and ready pulse, but WE stays 1 (no-op write).
- Undefined:
  - No be port.
  - UB=LB=0 whenever CE=0.

Test Plan:
- Reset → CE=UB=LB=OE=WE=1, ADDR=0, Data=Z, ready=0, busy=0.
- WAIT_CYCLES=1; SRAM model holds x1234 at x00042; read req → ADDR=x00042, OE=0 for 2 cycles; ready high in the 3rd cycle after the accept edge; rdata=x1234; busy low next cycle.
- Write req addr=x0BEEF, wdata=x00AB → Data=x00AB for 4 cycles; WE low exactly 2 cycles, starting 1 cycle after CE falls; read-back returns x00AB.
- Second req pulsed during a read's RD_ACC → ignored; exactly one ready pulse; SRAM contents unchanged.
- Reset raised during WR_PULSE → next cycle WE=1, CE=1, Data=Z, no ready pulse; a subsequent read of that address returns the pre-write value if the model commits only on WE rising.
- With SRAM_BYTE_LANE_EN, write be=10 data=xAB00 over existing x1234 → UB=0, LB=1 during the write; read-back = xAB34.
